// File: rtl/jpeg_stream_feeder.sv
// Purpose : JPEG scan-byte front end: unstuffs FF 00, intercepts markers, serialises bytes MSB-first, counts decoded blocks.
// Latency : byte accepted in cycle N drives bit 7 in cycle N+1 and bit 0 in N+8; marker/done pulses are registered (+1 cycle).
// Backpres: byte_ready_out comes only from registered state (LOAD, FF_CHECK, last bit of SHIFT); DRAIN and IDLE stall input.
//
// Ports:
//   clk_in, rst_n_in                 clock, async active-low reset
//   start_in                         begin a frame (IDLE only)
//   byte_in/byte_valid_in/byte_ready_out   scan byte valid/ready input
//   serial_out/serial_valid_out      one bit per cycle to the decoder
//   row_valid_in                     decoder row strobe (8 rows = 1 block)
//   marker_out/marker_valid_out      last intercepted marker code + pulse
//   block_count_out                  blocks completed this frame (saturating)
//   busy_out, frame_done_out, error_out   status
//
// Optional feature: define FEEDER_WATCHDOG_EN to bound the time spent in DRAIN by DRAIN_TIMEOUT cycles.
module jpeg_stream_feeder #(
  parameter int BLOCKS_PER_FRAME = 4800,
  parameter int DRAIN_TIMEOUT    = 65535
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic        byte_ready_out,
  output logic        serial_out,
  output logic        serial_valid_out,
  input  logic        row_valid_in,
  output logic [7:0]  marker_out,
  output logic        marker_valid_out,
  output logic [15:0] block_count_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        error_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_FF    = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // 17-bit so a block count of 0xFFFF can still be compared against the target.
  localparam logic [16:0] BPF17    = 17'(BLOCKS_PER_FRAME);
  localparam logic [15:0] WD_LIMIT = 16'(DRAIN_TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  row_q, row_d;
  logic [15:0] blk_q, blk_d;
  logic        err_q, err_d;
  logic [7:0]  marker_q, marker_d;
  logic        mvld_q, mvld_d;
  logic        done_q, done_d;
  logic        accept;

`ifdef FEEDER_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;
`else
  // DRAIN_TIMEOUT only matters when the watchdog is built in.
  logic unused_wd_limit;
  assign unused_wd_limit = ^WD_LIMIT;
`endif

  assign byte_ready_out   = (state_q == S_LOAD) || (state_q == S_FF) ||
                            ((state_q == S_SHIFT) && (idx_q == 3'd0));
  assign accept           = byte_valid_in && byte_ready_out;
  // Gated so the serial line idles low outside SHIFT.
  assign serial_out       = (state_q == S_SHIFT) && shreg_q[idx_q];
  assign serial_valid_out = (state_q == S_SHIFT);
  assign marker_out       = marker_q;
  assign marker_valid_out = mvld_q;
  assign block_count_out  = blk_q;
  assign busy_out         = (state_q != S_IDLE);
  assign frame_done_out   = done_q;
  assign error_out        = err_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    row_d    = row_q;
    blk_d    = blk_q;
    err_d    = err_q;
    marker_d = marker_q;
    mvld_d   = 1'b0;
    done_d   = 1'b0;
`ifdef FEEDER_WATCHDOG_EN
    wd_d     = 16'd0;
`endif

    // Row/block accounting runs in every active state; blk_d is the
    // post-increment count so DRAIN sees a same-cycle block completion.
    if (state_q != S_IDLE && row_valid_in) begin
      row_d = row_q + 3'd1;
      if (row_q == 3'd7) begin
        if (blk_q != 16'hFFFF) blk_d = blk_q + 16'd1;
        if ({1'b0, blk_q} >= BPF17) err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_LOAD;
          blk_d   = 16'd0;
          row_d   = 3'd0;
          err_d   = 1'b0;
        end
      end

      S_LOAD, S_SHIFT: begin
        if (state_q == S_SHIFT && idx_q != 3'd0) begin
          idx_d = idx_q - 3'd1;
        end else if (accept) begin
          if (byte_in != 8'hFF) begin
            shreg_d = byte_in;
            idx_d   = 3'd7;
            state_d = S_SHIFT;
          end else begin
            state_d = S_FF;
          end
        end else begin
          state_d = S_LOAD;
        end
      end

      S_FF: begin
        if (accept) begin
          if (byte_in == 8'h00) begin
            // Stuffed data byte: the FF itself is payload.
            shreg_d = 8'hFF;
            idx_d   = 3'd7;
            state_d = S_SHIFT;
          end else if (byte_in == 8'hFF) begin
            state_d = S_FF;
          end else if (byte_in[7:3] == 5'b11010) begin
            marker_d = byte_in;
            mvld_d   = 1'b1;
            state_d  = S_LOAD;
          end else if (byte_in == 8'hD9) begin
            marker_d = byte_in;
            mvld_d   = 1'b1;
            state_d  = S_DRAIN;
          end else begin
            marker_d = byte_in;
            mvld_d   = 1'b1;
            err_d    = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      S_DRAIN: begin
        if ({1'b0, blk_d} == BPF17) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
`ifdef FEEDER_WATCHDOG_EN
          wd_d = wd_q + 16'd1;
          if (wd_d == WD_LIMIT) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= S_IDLE;
      shreg_q  <= 8'h00;
      idx_q    <= 3'd0;
      row_q    <= 3'd0;
      blk_q    <= 16'd0;
      err_q    <= 1'b0;
      marker_q <= 8'h00;
      mvld_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FEEDER_WATCHDOG_EN
      wd_q     <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      blk_q    <= blk_d;
      err_q    <= err_d;
      marker_q <= marker_d;
      mvld_q   <= mvld_d;
      done_q   <= done_d;
`ifdef FEEDER_WATCHDOG_EN
      wd_q     <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_jpeg_stream_feeder.sv
module tb_jpeg_stream_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_d = 8'h00;
  logic        bvld = 1'b0;
  logic        brdy;
  logic        ser;
  logic        svld;
  logic        row = 1'b0;
  logic [7:0]  marker;
  logic        mvld;
  logic [15:0] blk;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jpeg_stream_feeder #(.BLOCKS_PER_FRAME(2), .DRAIN_TIMEOUT(65535)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
    .byte_in(byte_d), .byte_valid_in(bvld), .byte_ready_out(brdy),
    .serial_out(ser), .serial_valid_out(svld), .row_valid_in(row),
    .marker_out(marker), .marker_valid_out(mvld), .block_count_out(blk),
    .busy_out(busy), .frame_done_out(done), .error_out(err)
  );

`ifdef FEEDER_WATCHDOG_EN
  logic        w_start = 1'b0;
  logic [7:0]  w_byte = 8'h00;
  logic        w_bvld = 1'b0;
  logic        w_row = 1'b0;
  logic        w_brdy, w_ser, w_svld, w_mvld, w_busy, w_done, w_err;
  logic [7:0]  w_marker;
  logic [15:0] w_blk;

  jpeg_stream_feeder #(.BLOCKS_PER_FRAME(2), .DRAIN_TIMEOUT(10)) dut_wd (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(w_start),
    .byte_in(w_byte), .byte_valid_in(w_bvld), .byte_ready_out(w_brdy),
    .serial_out(w_ser), .serial_valid_out(w_svld), .row_valid_in(w_row),
    .marker_out(w_marker), .marker_valid_out(w_mvld), .block_count_out(w_blk),
    .busy_out(w_busy), .frame_done_out(w_done), .error_out(w_err)
  );
`endif

  // Output monitor, sampled on the falling edge.
  int         cyc = 0;
  logic       bits[$];
  int         bit_cyc[$];
  int         mk_cnt = 0;
  logic [7:0] mk_last = 8'h00;
  int         done_cnt = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (svld) begin
      bits.push_back(ser);
      bit_cyc.push_back(cyc);
    end
    if (mvld) begin
      mk_cnt  = mk_cnt + 1;
      mk_last = marker;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bits.delete();
    bit_cyc.delete();
    mk_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok     = 1'b0;
    byte_d = b;
    bvld   = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = brdy;
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic check_bits(input string name, input logic [15:0] exp);
    logic [15:0] got;
    got = 16'h0000;
    checks++;
    if (bits.size() != 16) begin
      errors++;
      $display("FAIL %s_count: got %0d bits, expected 16", name, bits.size());
    end else begin
      for (int i = 0; i < 16; i++) got[15-i] = bits[i];
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_bits: got %h expected %h", name, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({brdy, svld, ser, mvld, busy, done, err, marker, blk} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {brdy, svld, ser, mvld, busy, done, err, marker, blk});
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({brdy, svld, busy, err, blk} !== 20'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected zero", {brdy, svld, busy, err, blk});
    end
    pulse_start();
    checks++;
    if (busy !== 1'b1 || brdy !== 1'b1) begin
      errors++;
      $display("FAIL start_load: busy=%b ready=%b expected 1 1", busy, brdy);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_byte(8'hA5);
    // Cycle right after the accept must already carry bit 7 (=1).
    checks++;
    if (svld !== 1'b1 || ser !== 1'b1) begin
      errors++;
      $display("FAIL first_bit_latency: valid=%b bit=%b expected 1 1", svld, ser);
    end
    send_byte(8'h3C);
    bvld = 1'b0;
    repeat (12) tick();
    check_bits("b2b", 16'hA53C);
    checks++;
    if (bit_cyc.size() != 16 || (bit_cyc[15] - bit_cyc[0]) != 15) begin
      errors++;
      $display("FAIL b2b_bubble: span %0d expected 15",
               bit_cyc.size() == 16 ? bit_cyc[15] - bit_cyc[0] : -1);
    end
  endtask

  task automatic test_stuffing();
    clear_mon();
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h00);
    bvld = 1'b0;
    repeat (12) tick();
    check_bits("stuff", 16'hFFFF);
    checks++;
    if (mk_cnt != 0) begin
      errors++;
      $display("FAIL stuff_marker: got %0d marker pulses expected 0", mk_cnt);
    end
  endtask

  task automatic test_restart_marker();
    clear_mon();
    send_byte(8'h12);
    send_byte(8'hFF);
    send_byte(8'hD3);
    send_byte(8'h34);
    bvld = 1'b0;
    repeat (12) tick();
    check_bits("rst_marker", 16'h1234);
    checks++;
    if (mk_cnt != 1 || mk_last !== 8'hD3) begin
      errors++;
      $display("FAIL rst_marker_pulse: got %0d pulses value %h expected 1 d3", mk_cnt, mk_last);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rst_marker_error: got %b expected 0", err);
    end
  endtask

  task automatic test_eoi_drain();
    clear_mon();
    send_byte(8'hFF);
    send_byte(8'hD9);
    bvld = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || brdy !== 1'b0 || svld !== 1'b0 || mk_last !== 8'hD9 || blk !== 16'd0) begin
      errors++;
      $display("FAIL drain_entry: busy=%b rdy=%b svld=%b mk=%h blk=%0d expected 1 0 0 d9 0",
               busy, brdy, svld, mk_last, blk);
    end
    for (int r = 1; r <= 16; r++) begin
      row = 1'b1;
      tick();
      row = 1'b0;
      if (r == 8) begin
        checks++;
        if (blk !== 16'd1) begin
          errors++;
          $display("FAIL block_step1: got %0d expected 1", blk);
        end
        // start outside IDLE must be ignored
        pulse_start();
        checks++;
        if (blk !== 16'd1 || brdy !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL start_ignored: blk=%0d rdy=%b busy=%b expected 1 0 1", blk, brdy, busy);
        end
      end
      if (r == 15) begin
        checks++;
        if (done_cnt != 0 || blk !== 16'd1) begin
          errors++;
          $display("FAIL early_done: done_cnt=%0d blk=%0d expected 0 1", done_cnt, blk);
        end
      end
      if (r == 16) begin
        checks++;
        if (done !== 1'b1 || blk !== 16'd2) begin
          errors++;
          $display("FAIL done_after_row16: done=%b blk=%0d expected 1 2", done, blk);
        end
      end
      tick();
    end
    repeat (3) tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit: done_cnt=%0d busy=%b err=%b expected 1 0 0", done_cnt, busy, err);
    end
  endtask

  task automatic test_bad_marker();
    clear_mon();
    pulse_start();
    send_byte(8'hFF);
    send_byte(8'hC4);
    bvld = 1'b0;
    tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || mk_last !== 8'hC4 || done_cnt != 0) begin
      errors++;
      $display("FAIL bad_marker: err=%b busy=%b mk=%h done_cnt=%0d expected 1 0 c4 0",
               err, busy, mk_last, done_cnt);
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clears_error: err=%b busy=%b expected 0 1", err, busy);
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h81);
    bvld = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    clear_mon();
    checks++;
    if (svld !== 1'b0 || ser !== 1'b0 || busy !== 1'b0 || brdy !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: svld=%b ser=%b busy=%b rdy=%b expected 0 0 0 0", svld, ser, busy, brdy);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (bits.size() != 0) begin
      errors++;
      $display("FAIL partial_after_reset: got %0d bits expected 0", bits.size());
    end
  endtask

`ifdef FEEDER_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    n = -1;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    w_byte  = 8'hFF;
    w_bvld  = 1'b1;
    tick();
    w_byte  = 8'hD9;
    tick();
    w_bvld  = 1'b0;
    for (int i = 1; i <= 30 && n < 0; i++) begin
      tick();
      if (w_done) n = i;
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL watchdog_latency: got %0d expected 10", n);
    end
    checks++;
    if (w_err !== 1'b1 || w_busy !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_status: err=%b busy=%b expected 1 0", w_err, w_busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stuffing();
    test_restart_marker();
    test_eoi_drain();
    test_bad_marker();
    test_reset_midframe();
`ifdef FEEDER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
